carp_branch_predictor: RTL and testbench

//  Parametrised fetch-stage predictor for the CARP pipeline: direct-mapped BTB + 2-bit PHT.

---
 rtl/carp_bp_pkg.sv | 34 +++
 rtl/carp_btb.sv | 58 +++++
 rtl/carp_branch_predictor.sv | 137 +++++++++++++
 tb/tb_carp_branch_predictor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carp_bp_pkg.sv
// Shared types and helpers for the CARP fetch-stage branch predictor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package carp_bp_pkg;

    // 2-bit saturating prediction counter; MSB set means "predict taken".
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    // Field widths of the default predictor configuration.
    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = 10;

    // One BTB entry in the default configuration (XLEN=32, TAG_W=10).
    typedef struct packed {
        logic                valid;
        logic                jmp;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    // Saturating counter step: stops at CTR_ST going up and CTR_SNT going down.
    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        if (taken) begin
            return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
        end
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/carp_btb.sv
// Direct-mapped branch target buffer: valid/jmp/tag/target per entry.
// Latency: combinational reads (lookup and target-compare ports); write lands on the next CLK edge.
// Backpressure: none; a write is accepted every cycle, reads see the pre-edge contents.
module carp_btb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int TAG_W = 10,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    // fetch lookup port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_jmp,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    // execute-side read used to check the predicted target of a resolved branch
    input  logic [IDX_W-1:0] cmp_idx,
    output logic [XLEN-1:0]  cmp_target,
    // training write
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  logic             wr_jmp
);

    typedef struct packed {
        logic             valid;
        logic             jmp;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t mem [DEPTH];

    // Reset clears every field so no stale target can leak into a compare; a write replaces the whole entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid: 1'b1, jmp: wr_jmp, tag: wr_tag, target: wr_target};
        end
    end

    // Read ports return the pre-edge contents (read-old on a same-cycle write).
    always_comb begin
        rd_valid   = mem[rd_idx].valid;
        rd_jmp     = mem[rd_idx].jmp;
        rd_tag     = mem[rd_idx].tag;
        rd_target  = mem[rd_idx].target;
        cmp_target = mem[cmp_idx].target;
    end

endmodule

// File: rtl/carp_branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB plus 2-bit PHT; optional gshare indexing (CARP_BP_GSHARE_EN).
// Latency: prediction is combinational from F_PC; training and MISPRED/MISP_CNT take effect at the next CLK edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
module carp_branch_predictor
    import carp_bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 32,
    parameter int PHT_DEPTH = 256,
    parameter int TAG_W     = 10,
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = $clog2(PHT_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 F_VALID,
    input  logic [XLEN-1:0]      F_PC,
    output logic                 P_TAKEN,
    output logic [XLEN-1:0]      P_TARGET,
    output logic [PHT_IDX_W-1:0] P_IDX,
    input  logic                 U_VALID,
    input  logic [XLEN-1:0]      U_PC,
    input  logic [PHT_IDX_W-1:0] U_IDX,
    input  logic                 U_IS_BR,
    input  logic                 U_IS_JMP,
    input  logic                 U_TAKEN,
    input  logic [XLEN-1:0]      U_TARGET,
    input  logic                 U_PRED,
    output logic                 MISPRED,
    output logic [15:0]          MISP_CNT
);

    localparam int BTB_IDX_W = $clog2(BTB_DEPTH);

    if (BTB_DEPTH < 4 || (1 << BTB_IDX_W) != BTB_DEPTH ||
        PHT_DEPTH < 4 || (1 << PHT_IDX_W) != PHT_DEPTH ||
        GHR_W < 2 || GHR_W > PHT_IDX_W ||
        BTB_IDX_W + 2 + TAG_W > XLEN || PHT_IDX_W + 2 > XLEN) begin : g_bad_cfg
        $error("carp_branch_predictor: unsupported parameter combination");
    end

    logic [BTB_IDX_W-1:0] f_bidx, u_bidx;
    logic [TAG_W-1:0]     f_tag, u_tag;
    logic                 rd_valid, rd_jmp;
    logic [TAG_W-1:0]     rd_tag;
    logic [XLEN-1:0]      rd_target, cmp_target;
    logic [PHT_IDX_W-1:0] f_pidx;
    logic                 u_upd, u_br, u_misp;
    logic                 unused_upc;
    ctr_t                 pht [PHT_DEPTH];

    assign f_bidx = F_PC[BTB_IDX_W+1:2];
    assign f_tag  = F_PC[BTB_IDX_W+2 +: TAG_W];
    assign u_bidx = U_PC[BTB_IDX_W+1:2];
    assign u_tag  = U_PC[BTB_IDX_W+2 +: TAG_W];
    // Only the index and tag fields of U_PC matter.
    assign unused_upc = ^U_PC;

    // Both flags set is illegal and is handled as a jump (no PHT/GHR training).
    assign u_upd  = U_VALID && (U_IS_BR || U_IS_JMP);
    assign u_br   = U_VALID && U_IS_BR && !U_IS_JMP;
    // Target check uses the entry as it stood before this edge's write.
    assign u_misp = u_upd && ((U_PRED != U_TAKEN) ||
                              (U_PRED && U_TAKEN && (U_TARGET != cmp_target)));

    carp_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH),
        .TAG_W (TAG_W),
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rd_idx     (f_bidx),
        .rd_valid   (rd_valid),
        .rd_jmp     (rd_jmp),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .cmp_idx    (u_bidx),
        .cmp_target (cmp_target),
        .wr_en      (u_upd && U_TAKEN),
        .wr_idx     (u_bidx),
        .wr_tag     (u_tag),
        .wr_target  (U_TARGET),
        .wr_jmp     (U_IS_JMP)
    );

`ifdef CARP_BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign f_pidx = F_PC[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);

    // Global history shifts in resolved branch outcomes only (non-speculative).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ghr <= '0;
        end else if (u_br) begin
            ghr <= {ghr[GHR_W-2:0], U_TAKEN};
        end
    end
`else
    assign f_pidx = F_PC[PHT_IDX_W+1:2];
`endif

    // Lookup: jumps in the BTB are always taken, branches follow the counter MSB; wrap on +4 is intended.
    always_comb begin
        P_IDX    = f_pidx;
        P_TAKEN  = F_VALID && rd_valid && (rd_tag == f_tag) && (rd_jmp || pht[f_pidx][1]);
        P_TARGET = P_TAKEN ? rd_target : F_PC + XLEN'(4);
    end

    // PHT trains on conditional branches at the index captured at fetch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= CTR_WNT;
            end
        end else if (u_br) begin
            pht[U_IDX] <= ctr_next(pht[U_IDX], U_TAKEN);
        end
    end

    // Mispredict flag reflects the latest update strobe; the counter wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MISPRED  <= 1'b0;
            MISP_CNT <= '0;
        end else if (U_VALID) begin
            MISPRED  <= u_misp;
            MISP_CNT <= MISP_CNT + 16'(u_misp);
        end
    end

    a_br_and_jmp : assert property (@(posedge CLK) disable iff (!RST_N)
                                    !(U_VALID && U_IS_BR && U_IS_JMP));

endmodule

// File: tb/tb_carp_branch_predictor.sv
// Randomised + directed scoreboard bench for carp_branch_predictor.
// Stimulus pushes expected lookup/update results from a behavioural model; a monitor pops and compares.
// Registered outputs are checked on the falling edge after the update's rising edge.
module tb_carp_branch_predictor;
    import carp_bp_pkg::*;

    localparam int XLEN      = 32;
    localparam int BTB_DEPTH = 32;
    localparam int PHT_DEPTH = 256;
    localparam int TAG_W     = 10;
    localparam int GHR_W     = 8;
    localparam int BTB_IDX_W = 5;
    localparam int PHT_IDX_W = 8;

    logic                 CLK;
    logic                 RST_N;
    logic                 F_VALID;
    logic [XLEN-1:0]      F_PC;
    logic                 P_TAKEN;
    logic [XLEN-1:0]      P_TARGET;
    logic [PHT_IDX_W-1:0] P_IDX;
    logic                 U_VALID;
    logic [XLEN-1:0]      U_PC;
    logic [PHT_IDX_W-1:0] U_IDX;
    logic                 U_IS_BR;
    logic                 U_IS_JMP;
    logic                 U_TAKEN;
    logic [XLEN-1:0]      U_TARGET;
    logic                 U_PRED;
    logic                 MISPRED;
    logic [15:0]          MISP_CNT;

    carp_branch_predictor #(
        .XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH), .PHT_DEPTH(PHT_DEPTH),
        .TAG_W(TAG_W), .GHR_W(GHR_W), .PHT_IDX_W(PHT_IDX_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .F_VALID(F_VALID), .F_PC(F_PC),
        .P_TAKEN(P_TAKEN), .P_TARGET(P_TARGET), .P_IDX(P_IDX),
        .U_VALID(U_VALID), .U_PC(U_PC), .U_IDX(U_IDX), .U_IS_BR(U_IS_BR),
        .U_IS_JMP(U_IS_JMP), .U_TAKEN(U_TAKEN), .U_TARGET(U_TARGET), .U_PRED(U_PRED),
        .MISPRED(MISPRED), .MISP_CNT(MISP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    btb_entry_t m_btb [BTB_DEPTH];
    int         m_pht [PHT_DEPTH];
    int         m_ghr;
    int         m_cnt;

    function automatic int m_bidx(logic [31:0] pc);
        return int'((pc >> 2) % BTB_DEPTH);
    endfunction

    function automatic int m_tag(logic [31:0] pc);
        return int'((pc >> (2 + BTB_IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic int m_pidx(logic [31:0] pc);
        int base;
        base = int'((pc >> 2) % PHT_DEPTH);
`ifdef CARP_BP_GSHARE_EN
        base = base ^ m_ghr;
`endif
        return base;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < BTB_DEPTH; i++) m_btb[i] = '0;
        for (int i = 0; i < PHT_DEPTH; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_cnt = 0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct { bit tk; logic [31:0] tgt; int idx; } lk_t;
    typedef struct { bit misp; int cnt; } rg_t;
    lk_t lq[$];
    rg_t rq[$];
    bit  lk_act = 1'b0;
    bit  u_prev = 1'b0;

    always @(posedge CLK) u_prev <= U_VALID && RST_N;

    // Monitor: lookup outputs every active step, registered outputs after each update edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (lk_act) begin
                if (lq.size() == 0) begin
                    chk("lookup_queue_empty", 32'd1, 32'd0);
                end else begin
                    lk_t e;
                    e = lq.pop_front();
                    chk("p_taken",  {31'd0, P_TAKEN}, {31'd0, e.tk});
                    chk("p_target", P_TARGET, e.tgt);
                    chk("p_idx",    {24'd0, P_IDX}, e.idx);
                end
            end
            if (u_prev) begin
                if (rq.size() == 0) begin
                    chk("update_queue_empty", 32'd1, 32'd0);
                end else begin
                    rg_t r;
                    r = rq.pop_front();
                    chk("mispred",  {31'd0, MISPRED}, {31'd0, r.misp});
                    chk("misp_cnt", {16'd0, MISP_CNT}, r.cnt);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit fv, input logic [31:0] fpc,
                        input bit uv, input logic [31:0] upc, input int uidx,
                        input bit ubr, input bit ujmp, input bit ut,
                        input logic [31:0] utgt, input bit upred);
        int  b, ub, pi;
        bit  tk, hit, misp;
        @(posedge CLK);
        #1;
        F_VALID = fv;  F_PC = fpc;
        U_VALID = uv;  U_PC = upc;  U_IDX = PHT_IDX_W'(uidx);
        U_IS_BR = ubr; U_IS_JMP = ujmp; U_TAKEN = ut; U_TARGET = utgt; U_PRED = upred;
        lk_act = 1'b1;
        // expected lookup from the state before this edge
        b   = m_bidx(fpc);
        pi  = m_pidx(fpc);
        hit = m_btb[b].valid && (int'(m_btb[b].tag) == m_tag(fpc));
        tk  = fv && hit && (m_btb[b].jmp || m_pht[pi] >= 2);
        lq.push_back('{tk: tk, tgt: tk ? m_btb[b].target : fpc + 32'd4, idx: pi});
        // apply update to the model
        if (uv) begin
            misp = 1'b0;
            if (ubr || ujmp) begin
                ub   = m_bidx(upc);
                misp = (upred != ut) || (upred && ut && utgt != m_btb[ub].target);
                if (ubr && !ujmp) begin
                    if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
                    else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
`ifdef CARP_BP_GSHARE_EN
                    m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << GHR_W);
`endif
                end
                if (ut) begin
                    m_btb[ub] = '{valid: 1'b1, jmp: ujmp, tag: TAG_W'(m_tag(upc)), target: utgt};
                end
            end
            if (misp) m_cnt = (m_cnt + 1) % 65536;
            rq.push_back('{misp: misp, cnt: m_cnt});
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd_br(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pred);
        step(1'b0, 32'h0, 1'b1, pc, m_pidx(pc), 1'b1, 1'b0, t, tgt, pred);
    endtask

    task automatic upd_jmp(input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
        step(1'b0, 32'h0, 1'b1, pc, m_pidx(pc), 1'b0, 1'b1, 1'b1, tgt, pred);
    endtask

    // Drive an update then pull reset before its edge; the write must not survive.
    task automatic reset_mid();
        @(posedge CLK);
        #1;
        lk_act = 1'b0;
        F_VALID = 1'b0;
        U_VALID = 1'b1; U_PC = 32'h100; U_IDX = '0; U_IS_BR = 1'b0; U_IS_JMP = 1'b1;
        U_TAKEN = 1'b1; U_TARGET = 32'h444; U_PRED = 1'b0;
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        m_reset();
        #1;
        chk("rst_async_cnt", {16'd0, MISP_CNT}, m_cnt);
        @(posedge CLK);
        #2;
        U_VALID = 1'b0;
        RST_N   = 1'b1;
        chk("rst_mispred", {31'd0, MISPRED}, 32'd0);
        chk("rst_cnt",     {16'd0, MISP_CNT}, m_cnt);
    endtask

    initial begin
        logic [31:0] pc, upc, tgt;
        int kind;
        bit t;
        RST_N = 1'b0;
        F_VALID = 1'b0; F_PC = '0; U_VALID = 1'b0; U_PC = '0; U_IDX = '0;
        U_IS_BR = 1'b0; U_IS_JMP = 1'b0; U_TAKEN = 1'b0; U_TARGET = '0; U_PRED = 1'b0;
        m_reset();
        #12;
        chk("reset_mispred", {31'd0, MISPRED}, 32'd0);
        chk("reset_cnt",     {16'd0, MISP_CNT}, m_cnt);
        #10;
        RST_N = 1'b1;

        // post-reset lookups, including F_VALID=0 and PC+4 wrap
        look(32'h100);
        look(32'h7ff0);
        look(32'hFFFF_FFFC);
        step(1'b0, 32'h100, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // train branch 0x100 -> 0x80 taken twice, then look it up
        upd_br(32'h100, 1'b1, 32'h80, 1'b0);
        upd_br(32'h100, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        // saturate up, then four not-taken updates saturate down
        upd_br(32'h100, 1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 4; i++) upd_br(32'h100, 1'b0, 32'h80, 1'b1);
        look(32'h100);

        // jal 0x40 -> 0x200, its alias misses
        upd_jmp(32'h40, 32'h200, 1'b0);
        look(32'h40);
        look(32'h40 + 4 * BTB_DEPTH);
        // wrong target on a correctly predicted taken jump
        upd_jmp(32'h40, 32'h240, 1'b1);
        look(32'h40);

        // same-cycle lookup and update of 0x100: read-old, then new
        step(1'b1, 32'h100, 1'b1, 32'h100, m_pidx(32'h100), 1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        look(32'h100);
        // update with neither flag: MISPRED clears, no state change
        step(1'b1, 32'h100, 1'b1, 32'h100, 0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        look(32'h100);

        reset_mid();
        look(32'h100);
        look(32'h40);

        // randomised mix over a small aliasing PC set
        for (int n = 0; n < 400; n++) begin
            pc   = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 2);
            upc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 2);
            tgt  = {$urandom_range(0, 7), 2'b00};
            kind = $urandom_range(0, 4);
            t    = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), pc,
                 1'($urandom_range(0, 2) != 0), upc,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, PHT_DEPTH - 1) : m_pidx(upc),
                 kind >= 2, kind == 1, t, tgt, 1'($urandom_range(0, 1)));
        end

        // 65536 mispredicts from reset wrap the counter back to zero
        reset_mid();
        for (int n = 0; n < 65536; n++) upd_br(32'h100, 1'b0, 32'h80, 1'b1);

        @(posedge CLK);
        #1;
        lk_act  = 1'b0;
        U_VALID = 1'b0;
        F_VALID = 1'b0;
        @(negedge CLK);
        #1;
        chk("wrap_cnt", {16'd0, MISP_CNT}, m_cnt);
        chk("lq_drained", lq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
